// File: rtl/md_sequencer_pkg.sv
// md_sequencer_pkg
// Shared definitions for the multiply/divide sequencer and the pipeline
// control logic around it: MD op codes, default latencies, the HI/LO Tnew
// class used by the forwarding/stall units, and FSM state encodings.
package md_sequencer_pkg;

  // E-stage multiply/divide op codes (md_op_e). Codes 9..15 behave as NONE.
  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  // Default busy cycles following the issue cycle.
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  // Tnew classes seen by the forwarding and stall units. MFHI/MFLO produce
  // their value at the end of E, so a consumer one stage behind waits one cycle.
  typedef enum logic [1:0] {
    TNEW_0 = 2'd0,
    TNEW_1 = 2'd1,
    TNEW_2 = 2'd2
  } tnew_t;
  localparam tnew_t TNEW_HILO = TNEW_1;

  // Sequencer FSM encodings.
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  // True for the four ops that occupy the multi-cycle unit.
  function automatic logic is_arith_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// md_arith
// Combinational multiply/divide datapath. Keeps the sign handling and the
// divide corner cases out of the sequencing FSM.
// Ports:
//   op       in  4   MD op code (only MULT/MULTU/DIV/DIVU produce results)
//   rs, rt   in  32  operands (rs = multiplicand / dividend)
//   res_hi   out 32  product high word or remainder
//   res_lo   out 32  product low word or quotient
//   div_zero out 1   DIV/DIVU with rt == 0 (result must be discarded)
module md_arith
  import md_sequencer_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic        signed_op;
  logic        neg_res;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [63:0] prod_mag;
  logic [63:0] prod;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  // Everything is done on magnitudes and the sign is re-applied at the end.
  // This covers 0x80000000 naturally: its magnitude is representable unsigned
  // and negating the 0x80000000 quotient wraps back to 0x80000000.
  always_comb begin
    signed_op = (op == MD_MULT) || (op == MD_DIV);
    neg_res   = signed_op && (rs[31] ^ rt[31]);
    a_mag     = (signed_op && rs[31]) ? (~rs + 32'd1) : rs;
    b_mag     = (signed_op && rt[31]) ? (~rt + 32'd1) : rt;

    prod_mag  = {32'd0, a_mag} * {32'd0, b_mag};
    prod      = neg_res ? (64'd0 - prod_mag) : prod_mag;

    // Divisor forced to 1 on divide-by-zero so the datapath stays defined;
    // the result is thrown away via div_zero.
    b_safe    = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag     = a_mag / b_safe;
    r_mag     = a_mag % b_safe;
    quot      = neg_res ? (32'd0 - q_mag) : q_mag;
    rem       = (signed_op && rs[31]) ? (32'd0 - r_mag) : r_mag;

    res_hi    = '0;
    res_lo    = '0;
    div_zero  = 1'b0;
    case (op)
      MD_MULT, MD_MULTU: begin
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      MD_DIV, MD_DIVU: begin
        res_hi   = rem;
        res_lo   = quot;
        div_zero = (rt == 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// md_sequencer
// E-stage multiply/divide sequencer. Owns HI/LO, models MULT/DIV latency,
// executes MTHI/MTLO and raises the D-stage stall for HI/LO consumers.
// Ports:
//   clk, reset   in   clock, synchronous active-low reset
//   md_op_e      in   4   E-stage MD op code
//   rs_e, rt_e   in   32  forwarded operands
//   md_use_d     in   1   D-stage instruction touches HI/LO or the MD unit
//   busy         out  1   operation in flight
//   start        out  1   arithmetic op accepted this cycle
//   hi, lo       out  32  committed HI/LO
//   stall_md     out  1   hold the D-stage instruction
//   state_dbg    out  1   FSM state (ST_IDLE / ST_RUN)
//
// Handshake: an arithmetic op on md_op_e is the request ("valid") and !busy
// is "ready"; start = valid & ready marks the single accepting cycle. Ops
// presented while busy are not accepted and are not retried by this block.
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
)(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op_e,
  input  logic [31:0] rs_e,
  input  logic [31:0] rt_e,
  input  logic        md_use_d,
  output logic        busy,
  output logic        start,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        stall_md,
  output logic        state_dbg
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAX_CYCLES + 1);

  logic             state;
  logic [CNT_W-1:0] counter;
  logic [31:0]      pending_hi;
  logic [31:0]      pending_lo;
  logic             pending_zero;

  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic             div_zero;

  md_arith u_arith (
    .op       (md_op_e),
    .rs       (rs_e),
    .rt       (rt_e),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  assign busy      = (state == ST_RUN);
  assign start     = is_arith_op(md_op_e) && !busy;
  // Covering the issue cycle as well as the busy cycles lets the dependent
  // instruction enter E only after the commit edge.
  assign stall_md  = md_use_d && (busy || start);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      counter      <= '0;
      hi           <= '0;
      lo           <= '0;
      pending_hi   <= '0;
      pending_lo   <= '0;
      pending_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            pending_hi   <= res_hi;
            pending_lo   <= res_lo;
            pending_zero <= div_zero;
            counter      <= ((md_op_e == MD_MULT) || (md_op_e == MD_MULTU))
                            ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            state        <= ST_RUN;
          end else if (md_op_e == MD_MTHI) begin
            hi <= rs_e;
          end else if (md_op_e == MD_MTLO) begin
            lo <= rs_e;
          end
        end
        ST_RUN: begin
          // Last busy cycle: commit so new HI/LO appear on the edge busy falls.
          if (counter == CNT_W'(1)) begin
            if (!pending_zero) begin
              hi <= pending_hi;
              lo <= pending_lo;
            end
            counter <= '0;
            state   <= ST_IDLE;
          end else begin
            counter <= counter - CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer
// Directed bench for md_sequencer. Drivers push the expected {hi,lo} of each
// arithmetic op into exp_q; a monitor pops and compares on every commit edge
// (busy falling outside reset). Drivers also check cycle-level timing.
module tb_md_sequencer;
  import md_sequencer_pkg::*;

  logic        clk;
  logic        reset;
  logic [3:0]  md_op_e;
  logic [31:0] rs_e;
  logic [31:0] rt_e;
  logic        md_use_d;
  logic        busy;
  logic        start;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        stall_md;
  logic        state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;
  logic        busy_q;
  logic        rst_q;

  md_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .md_op_e   (md_op_e),
    .rs_e      (rs_e),
    .rt_e      (rt_e),
    .md_use_d  (md_use_d),
    .busy      (busy),
    .start     (start),
    .hi        (hi),
    .lo        (lo),
    .stall_md  (stall_md),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin
    busy_q <= busy;
    rst_q  <= reset;
  end

  always @(negedge clk) begin
    if (busy_q === 1'b1 && busy === 1'b0 && rst_q === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL commit_unexpected: got hi=%h lo=%h expected no commit", hi, lo);
      end else begin
        mon_exp = exp_q.pop_front();
        check("commit_hilo", {hi, lo}, mon_exp);
      end
    end
  end

  // ---------------- drivers ----------------
  // Issue an arithmetic op, check busy/stall for n busy cycles and the drop.
  // inject_at > 0 presents a competing MULT on that busy cycle.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input int n, input logic use_d, input int inject_at);
    @(negedge clk);
    md_op_e  = op;
    rs_e     = a;
    rt_e     = b;
    md_use_d = use_d;
    #1;
    check("start_issue", start, 1);
    check("stall_issue", stall_md, use_d);
    exp_q.push_back(exp);
    @(negedge clk);
    md_op_e = MD_NONE;
    for (int i = 1; i <= n; i++) begin
      if (i == inject_at) begin
        md_op_e = MD_MULT;
        rs_e    = 32'd5;
        rt_e    = 32'd5;
      end
      #1;
      if (i == inject_at) check("start_while_busy", start, 0);
      check("busy_high", busy, 1);
      check("stall_busy", stall_md, use_d);
      @(negedge clk);
      md_op_e = MD_NONE;
    end
    // Dependent instruction (MFLO in the stall case) now reaches E.
    md_use_d = 1'b0;
    md_op_e  = use_d ? MD_MFLO : MD_NONE;
    #1;
    check("busy_drop", busy, 0);
    check("stall_clear", stall_md, 0);
    if (use_d) check("mflo_value", lo, exp[31:0]);
  endtask

  task automatic move_to(input logic [3:0] op, input logic [31:0] val, input logic [63:0] exp);
    @(negedge clk);
    md_op_e = op;
    rs_e    = val;
    #1;
    check("mt_no_start", start, 0);
    @(negedge clk);
    md_op_e = MD_NONE;
    #1;
    check("mt_hilo", {hi, lo}, exp);
    check("mt_busy", busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset    = 1'b0;
    md_op_e  = MD_NONE;
    rs_e     = '0;
    rt_e     = '0;
    md_use_d = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_busy", busy, 0);
    check("reset_state", state_dbg, ST_IDLE);
    check("reset_stall", stall_md, 0);
    reset = 1'b1;

    issue(MD_MULT,  32'd3, 32'hFFFFFFFE, {32'hFFFFFFFF, 32'hFFFFFFFA}, 5, 1'b0, 0);
    issue(MD_MULTU, 32'd3, 32'hFFFFFFFE, {32'h00000002, 32'hFFFFFFFA}, 5, 1'b0, 0);
    issue(MD_DIV,   32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 10, 1'b0, 0);
    issue(MD_DIVU,  32'd7, 32'd2,        {32'h00000001, 32'h00000003}, 10, 1'b0, 0);
    move_to(MD_MTHI, 32'h00001234,       {32'h00001234, 32'h00000003});
    // Divide by zero: full latency, HI/LO untouched.
    issue(MD_DIV,   32'd55, 32'd0,       {32'h00001234, 32'h00000003}, 10, 1'b0, 0);
    issue(MD_DIV,   32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}, 10, 1'b0, 0);
    move_to(MD_MTLO, 32'hCAFEBABE,       {32'h00000000, 32'hCAFEBABE});
    // Competing MULT 5*5 on busy cycle 2 must be ignored.
    issue(MD_MULT,  32'h00010000, 32'h00010000, {32'h00000001, 32'h00000000}, 5, 1'b0, 2);
    // MFLO waiting in D.
    issue(MD_MULT,  32'd7, 32'd6,        {32'h00000000, 32'h0000002A}, 5, 1'b1, 0);

    // Reset on busy cycle 3 of a DIV aborts it.
    @(negedge clk);
    md_op_e = MD_DIV;
    rs_e    = 32'd100;
    rt_e    = 32'd7;
    @(negedge clk);
    md_op_e = MD_NONE;
    #1;
    check("abort_busy_c1", busy, 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("abort_hilo", {hi, lo}, 64'd0);
    check("abort_busy", busy, 0);
    check("abort_state", state_dbg, ST_IDLE);
    reset = 1'b1;

    issue(MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, {32'h00000000, 32'h00000001}, 5, 1'b0, 0);

    @(negedge clk);
    md_op_e = MD_NONE;
    repeat (2) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
